// File: rtl/uart_word_rx.sv
// 8N1 UART receiver that packs BUSW/8 bytes (MSB first) into one word; optional idle timeout via UART_WORD_RX_TIMEOUT_EN.
// Latency: dout_valid one cycle after the final stop-bit mid-sample; rx line to START is 3 cycles.
// No backpressure: words and error pulses are single-cycle strobes the consumer must catch.
module uart_word_rx #(
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 115200,
    parameter int BUSW     = 32
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            uart_rxd,
    output logic [BUSW-1:0] uart_dout,
    output logic            dout_valid,
    output logic            frame_err,
    output logic            timeout_err,
    output logic            busy
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int SAMPLE  = BPS_CNT / 2;
    localparam int NBYTES  = BUSW / 8;
    localparam int CW      = $clog2(BPS_CNT + 1);
    localparam int BCW     = $clog2(NBYTES + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_rx_s1;
    logic            r_rx_s2;
    logic            r_rx_d;
    logic [CW-1:0]   r_bps_cnt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_byte;
    logic [BUSW-1:0] r_word;
    logic [BCW-1:0]  r_byte_cnt;
    logic [BUSW-1:0] r_dout;
    logic            r_dout_valid;
    logic            r_frame_err;

    logic            w_fall;
    logic            w_mid;
    logic            w_last;
    logic            w_timeout;
    logic [BUSW-1:0] w_word_nxt;

    assign w_fall     = r_rx_d & ~r_rx_s2;
    assign w_mid      = (r_bps_cnt == CW'(SAMPLE));
    assign w_last     = (r_byte_cnt == BCW'(NBYTES - 1));
    assign w_word_nxt = (r_word << 8) | BUSW'(r_byte);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_rx_s1 <= uart_rxd;
            r_rx_s2 <= r_rx_s1;
            r_rx_d  <= r_rx_s2;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_fall) w_state_nxt = S_START;
            S_START: if (w_mid) w_state_nxt = r_rx_s2 ? S_IDLE : S_DATA;
            S_DATA:  if (w_mid && (r_bit_cnt == 3'd7)) w_state_nxt = S_STOP;
            S_STOP:  if (w_mid) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_bps_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_byte       <= '0;
            r_word       <= '0;
            r_byte_cnt   <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;
            r_frame_err  <= 1'b0;

            // Held at zero in IDLE so every frame starts with a fresh bit period.
            if (r_state == S_IDLE || r_bps_cnt == CW'(BPS_CNT - 1)) begin
                r_bps_cnt <= '0;
            end else begin
                r_bps_cnt <= r_bps_cnt + CW'(1);
            end

            if (r_state != S_DATA) begin
                r_bit_cnt <= '0;
            end else if (w_mid) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_byte    <= {r_rx_s2, r_byte[7:1]};
            end

            if (r_state == S_STOP && w_mid) begin
                if (r_rx_s2) begin
                    r_word <= w_word_nxt;
                    if (w_last) begin
                        r_dout       <= w_word_nxt;
                        r_dout_valid <= 1'b1;
                        r_byte_cnt   <= '0;
                    end else begin
                        r_byte_cnt <= r_byte_cnt + BCW'(1);
                    end
                end else begin
                    r_frame_err <= 1'b1;
                    r_word      <= '0;
                    r_byte_cnt  <= '0;
                end
            end else if (w_timeout) begin
                r_word     <= '0;
                r_byte_cnt <= '0;
            end
        end
    end

`ifdef UART_WORD_RX_TIMEOUT_EN
    localparam int TO_CNT = 20 * BPS_CNT;
    localparam int TW     = $clog2(TO_CNT + 1);

    logic [TW-1:0] r_idle_cnt;
    logic          r_timeout_err;

    assign w_timeout = (r_state == S_IDLE) && (r_byte_cnt != '0) &&
                       (r_idle_cnt == TW'(TO_CNT - 1));

    // Zero outside IDLE, so the count restarts on each return to IDLE.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_idle_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            if (r_state != S_IDLE || r_byte_cnt == '0 || w_timeout) begin
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + TW'(1);
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign uart_dout  = r_dout;
    assign dout_valid = r_dout_valid;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state != S_IDLE) || (r_byte_cnt != '0);

endmodule

// File: tb/tb_uart_word_rx.sv
// Bench for uart_word_rx: table of whole words, hand-built corner sequences, and random bytes
// scored against a byte-list model of the framing and word-packing rules.
module tb_uart_word_rx;

    localparam int CLK_FREQ = 1000000;
    localparam int UART_BPS = 100000;
    localparam int BUSW     = 32;
    localparam int BIT_CYC  = CLK_FREQ / UART_BPS;
    localparam int NBYTES   = BUSW / 8;

    logic            sys_clk = 1'b0;
    logic            sys_rst;
    logic            uart_rxd;
    logic [BUSW-1:0] uart_dout;
    logic            dout_valid;
    logic            frame_err;
    logic            timeout_err;
    logic            busy;

    uart_word_rx #(
        .CLK_FREQ(CLK_FREQ),
        .UART_BPS(UART_BPS),
        .BUSW    (BUSW)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .uart_rxd   (uart_rxd),
        .uart_dout  (uart_dout),
        .dout_valid (dout_valid),
        .frame_err  (frame_err),
        .timeout_err(timeout_err),
        .busy       (busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] data;
        int          gap;
        logic [31:0] exp;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] obs_q[$];
    logic [31:0] mdl_q[$];
    logic [7:0]  partial[$];
    logic [31:0] last_exp = '0;
    int          cnt_ferr = 0;
    int          cnt_terr = 0;
    int          cnt_overlap = 0;
    int          exp_ferr = 0;
    int          exp_terr = 0;

    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (dout_valid) obs_q.push_back(uart_dout);
            if (frame_err) cnt_ferr++;
            if (timeout_err) cnt_terr++;
            if (dout_valid && (frame_err || timeout_err)) cnt_overlap++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        uart_rxd = v;
        repeat (BIT_CYC) @(negedge sys_clk);
    endtask

    // Model: good bytes accumulate, a bad stop bit drops everything held, NBYTES bytes make a word.
    task automatic send_byte(input logic [7:0] b, input logic ok);
        logic [31:0] w;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(ok);
        if (!ok) drive_bit(1'b1);
        if (ok) begin
            partial.push_back(b);
            if (partial.size() == NBYTES) begin
                w = '0;
                foreach (partial[k]) w = (w << 8) | 32'(partial[k]);
                mdl_q.push_back(w);
                last_exp = w;
                partial.delete();
            end
        end else begin
            partial.delete();
            exp_ferr++;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = NBYTES - 1; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1);
    endtask

    task automatic idle(input int n);
        uart_rxd = 1'b1;
        repeat (n) @(negedge sys_clk);
`ifdef UART_WORD_RX_TIMEOUT_EN
        if (n >= 200 && partial.size() != 0) begin
            partial.delete();
            exp_terr++;
        end
`endif
    endtask

    task automatic checkpoint(input string name);
        idle(20);
        check({name, " word count"}, 64'(obs_q.size()), 64'(mdl_q.size()));
        while (obs_q.size() != 0 && mdl_q.size() != 0)
            check({name, " word"}, 64'(obs_q.pop_front()), 64'(mdl_q.pop_front()));
        obs_q.delete();
        mdl_q.delete();
        check({name, " frame_err count"}, 64'(cnt_ferr), 64'(exp_ferr));
        check({name, " timeout_err count"}, 64'(cnt_terr), 64'(exp_terr));
        check({name, " uart_dout hold"}, 64'(uart_dout), 64'(last_exp));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        logic [7:0] rb;
        logic       rok;

        tbl[0] = '{32'h12345678, 15, 32'h12345678};
        tbl[1] = '{32'hDEADBEEF,  0, 32'hDEADBEEF};
        tbl[2] = '{32'h0000FFFF, 12, 32'h0000FFFF};
        tbl[3] = '{32'h00000000,  3, 32'h00000000};
        tbl[4] = '{32'hFFFFFFFF,  0, 32'hFFFFFFFF};
        tbl[5] = '{32'h80000001, 25, 32'h80000001};

        sys_rst  = 1'b1;
        uart_rxd = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("reset uart_dout", 64'(uart_dout), 64'h0);
        check("reset dout_valid", 64'(dout_valid), 64'h0);
        check("reset frame_err", 64'(frame_err), 64'h0);
        check("reset timeout_err", 64'(timeout_err), 64'h0);
        check("reset busy", 64'(busy), 64'h0);
        sys_rst = 1'b0;
        repeat (3) @(negedge sys_clk);

        for (int i = 0; i < 6; i++) begin
            send_word(tbl[i].data);
            idle(tbl[i].gap);
        end
        idle(20);
        for (int i = 0; i < 6; i++)
            check($sformatf("table word %0d", i),
                  (i < obs_q.size()) ? 64'(obs_q[i]) : 64'hDEAD_0000_DEAD_0000,
                  64'(tbl[i].exp));
        checkpoint("table");

        // Short low pulse: receiver enters START, then rejects it at the mid-sample.
        uart_rxd = 1'b0;
        repeat (3) @(negedge sys_clk);
        uart_rxd = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("glitch in START busy", 64'(busy), 64'h1);
        repeat (12) @(negedge sys_clk);
        check("glitch back to IDLE busy", 64'(busy), 64'h0);
        checkpoint("glitch");

        send_byte(8'h11, 1'b1);
        send_byte(8'hAA, 1'b0);
        send_word(32'h01020304);
        checkpoint("frame error");

        send_byte(8'h21, 1'b1);
        send_byte(8'h43, 1'b1);
        idle(250);
        send_word(32'hCAFEF00D);
        checkpoint("timeout");

        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        check("pre-reset dout nonzero", 64'(uart_dout != '0), 64'h1);
        sys_rst = 1'b1;
        partial.delete();
        last_exp = '0;
        repeat (2) @(negedge sys_clk);
        check("mid-frame reset uart_dout", 64'(uart_dout), 64'h0);
        check("mid-frame reset dout_valid", 64'(dout_valid), 64'h0);
        check("mid-frame reset frame_err", 64'(frame_err), 64'h0);
        check("mid-frame reset timeout_err", 64'(timeout_err), 64'h0);
        check("mid-frame reset busy", 64'(busy), 64'h0);
        uart_rxd = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (3) @(negedge sys_clk);
        send_word(32'h0A0B0C0D);
        checkpoint("reset");

        for (int i = 0; i < 48; i++) begin
            rb  = 8'($urandom);
            rok = ($urandom_range(0, 7) != 0);
            send_byte(rb, rok);
            idle($urandom_range(0, 20));
        end
        checkpoint("random");

        check("valid overlapping an error pulse", 64'(cnt_overlap), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
